// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hexadecimal 7-segment driver with a frame-synchronous message load
// and an optional left-scroll of the displayed message.
module seg7_scan_driver #(
    parameter int NUM_DIGITS    = 4,
    parameter int CLK_DIV       = 50000,
    parameter int SCROLL_FRAMES = 64,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [4*NUM_DIGITS-1:0]   load_data,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic                      scroll_en,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     dig_an
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int FRM_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(SCROLL_FRAMES - 1);
    localparam logic             POL      = 1'(ACTIVE_LOW != 0);

    logic [DIV_W-1:0]                div_cnt;
    logic [IDX_W-1:0]                dig_idx;
    logic [FRM_W-1:0]                frame_cnt;
    logic [NUM_DIGITS-1:0][3:0]      disp_buf;
    logic [NUM_DIGITS-1:0][3:0]      shadow_buf;
    logic                            pending;

    logic                            tick;
    logic                            frame_end;
    logic [3:0]                      cur_nib;
    logic [6:0]                      glyph;
    logic [NUM_DIGITS-1:0]           dig_onehot;

    assign tick       = (div_cnt == DIV_LAST);
    assign frame_end  = tick && (dig_idx == IDX_LAST);
    assign load_ready = ~pending;
    assign cur_nib    = disp_buf[dig_idx];
    assign dig_onehot = NUM_DIGITS'(1) << dig_idx;

    // Lit-segment pattern, bit 0 = a ... bit 6 = g; polarity is applied at the output register.
    always_comb begin
        // NOTE: assigning a default before the case keeps this purely combinational (no latch).
        glyph = 7'h00;
        case (cur_nib)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            4'hF: glyph = 7'h71;
            default: glyph = 7'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the message buffers are plain registers, so they are cleared here to
            // guarantee a pending message cannot survive reset.
            div_cnt    <= '0;
            dig_idx    <= '0;
            frame_cnt  <= '0;
            disp_buf   <= '0;
            shadow_buf <= '0;
            pending    <= 1'b0;
            seg        <= {7{POL}};
            dig_an     <= {NUM_DIGITS{POL}};
        end else begin
            // NOTE: non-blocking assignments make every register see pre-edge values,
            // so the frame-end apply below reads the old shadow_buf and pending.
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                dig_idx <= (dig_idx == IDX_LAST) ? '0 : dig_idx + IDX_W'(1);
            end

            // Accepting and applying are mutually exclusive because both depend on pending.
            if (load_valid && !pending) begin
                shadow_buf <= load_data;
                pending    <= 1'b1;
            end

            if (frame_end) begin
                if (pending) begin
                    disp_buf  <= shadow_buf;
                    pending   <= 1'b0;
                    frame_cnt <= '0;
                end else if (scroll_en) begin
                    if (frame_cnt == FRM_LAST) begin
                        disp_buf  <= {disp_buf[0], disp_buf[NUM_DIGITS-1:1]};
                        frame_cnt <= '0;
                    end else begin
                        frame_cnt <= frame_cnt + FRM_W'(1);
                    end
                end
            end

            seg    <= (blank_mask[dig_idx] ? 7'h00 : glyph) ^ {7{POL}};
            dig_an <= dig_onehot ^ {NUM_DIGITS{POL}};
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: an active-low and an active-high instance share
// stimulus; expected per-cycle outputs are queued when stimulus is applied.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int CD = 4;
    localparam int SF = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic        scroll_en = 1'b0;
    logic [15:0] load_data = '0;
    logic [3:0]  blank_mask = '0;

    logic        load_ready, load_ready_hi;
    logic [6:0]  seg, seg_hi;
    logic [3:0]  dig_an, dig_an_hi;

    int checks = 0;
    int errors = 0;
    int k = 0;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] an;
        logic       rdy;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] cur_word = '0;

    seg7_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD), .SCROLL_FRAMES(SF), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .blank_mask(blank_mask), .scroll_en(scroll_en),
        .seg(seg), .dig_an(dig_an)
    );

    seg7_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD), .SCROLL_FRAMES(SF), .ACTIVE_LOW(0)) dut_hi (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready_hi),
        .load_data(load_data), .blank_mask(blank_mask), .scroll_en(scroll_en),
        .seg(seg_hi), .dig_an(dig_an_hi)
    );

    always #5 clk = ~clk;

    // k counts rising edges since the last edge that saw reset asserted.
    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Lit segments (bit 0 = a) for the standard hex glyphs.
    function automatic logic [6:0] lit(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[n];
    endfunction

    // Queue one full frame of active-low expectations; rdy bit c is load_ready in frame cycle c.
    task automatic push_frame(input logic [15:0] word, input logic [3:0] blank, input logic [15:0] rdy);
        exp_t e;
        for (int s = 0; s < ND; s++) begin
            for (int c = 0; c < CD; c++) begin
                e.seg = blank[s] ? 7'h7F : ~lit(word[4*s +: 4]);
                e.an  = ~(4'b0001 << s);
                e.rdy = rdy[s*CD + c];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_frame_start();
        int guard = 0;
        while ((k % (ND*CD)) != 0 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 64) begin
            errors++;
            $display("FAIL frame_align: k=%0d never reached a frame boundary", k);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back('{7'h7F, 4'hF, 1'b1});
        repeat (4) exp_q.push_back('{7'b1000000, 4'b1110, 1'b1});
        exp_q.push_back('{7'b1000000, 4'b1101, 1'b1});
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (seg !== e.seg || dig_an !== e.an || load_ready !== e.rdy ||
                seg_hi !== ~e.seg || dig_an_hi !== ~e.an || load_ready_hi !== e.rdy) begin
                errors++;
                $display("FAIL reset k=%0d: got seg=%b an=%b rdy=%b hi seg=%b an=%b rdy=%b; want seg=%b an=%b rdy=%b (hi inverted)",
                         k, seg, dig_an, load_ready, seg_hi, dig_an_hi, load_ready_hi, e.seg, e.an, e.rdy);
            end
        end
    endtask

    task automatic test_load_decode();
        exp_t e;
        logic [6:0] want [4];
        want = '{7'b0001000, 7'b1111001, 7'b0000000, 7'b0001110};
        load_valid = 1'b1;
        load_data  = 16'hF81A;
        push_frame(cur_word, 4'b0000, 16'h8000);
        for (int s = 0; s < ND; s++)
            for (int c = 0; c < CD; c++)
                exp_q.push_back('{want[s], ~(4'b0001 << s), 1'b1});
        for (int i = 0; i < 2*ND*CD; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (seg !== e.seg || dig_an !== e.an || load_ready !== e.rdy ||
                seg_hi !== ~e.seg || dig_an_hi !== ~e.an || load_ready_hi !== e.rdy) begin
                errors++;
                $display("FAIL load_decode k=%0d: got seg=%b an=%b rdy=%b hi seg=%b an=%b rdy=%b; want seg=%b an=%b rdy=%b (hi inverted)",
                         k, seg, dig_an, load_ready, seg_hi, dig_an_hi, load_ready_hi, e.seg, e.an, e.rdy);
            end
            if (i == 0) load_valid = 1'b0;
        end
        cur_word = 16'hF81A;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        load_valid = 1'b1;
        load_data  = 16'h1234;
        push_frame(cur_word, 4'b0000, 16'h8000);
        push_frame(16'h1234, 4'b0000, 16'h8000);
        push_frame(16'h5678, 4'b0000, 16'hFFFF);
        for (int i = 0; i < 3*ND*CD; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (seg !== e.seg || dig_an !== e.an || load_ready !== e.rdy ||
                seg_hi !== ~e.seg || dig_an_hi !== ~e.an || load_ready_hi !== e.rdy) begin
                errors++;
                $display("FAIL back_to_back k=%0d: got seg=%b an=%b rdy=%b hi seg=%b an=%b rdy=%b; want seg=%b an=%b rdy=%b (hi inverted)",
                         k, seg, dig_an, load_ready, seg_hi, dig_an_hi, load_ready_hi, e.seg, e.an, e.rdy);
            end
            if (i == 0)  load_data  = 16'h5678;
            if (i == 16) load_valid = 1'b0;
        end
        cur_word = 16'h5678;
    endtask

    task automatic test_scroll();
        exp_t e;
        load_valid = 1'b1;
        load_data  = 16'h3210;
        scroll_en  = 1'b1;
        push_frame(cur_word, 4'b0000, 16'h8000);
        push_frame(16'h3210, 4'b0000, 16'hFFFF);
        push_frame(16'h3210, 4'b0000, 16'hFFFF);
        push_frame(16'h0321, 4'b0000, 16'hFFFF);
        push_frame(16'h0321, 4'b0000, 16'hFFFF);
        repeat (4) push_frame(16'h1032, 4'b0000, 16'hFFFF);
        for (int i = 0; i < 9*ND*CD; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (seg !== e.seg || dig_an !== e.an || load_ready !== e.rdy ||
                seg_hi !== ~e.seg || dig_an_hi !== ~e.an || load_ready_hi !== e.rdy) begin
                errors++;
                $display("FAIL scroll k=%0d: got seg=%b an=%b rdy=%b hi seg=%b an=%b rdy=%b; want seg=%b an=%b rdy=%b (hi inverted)",
                         k, seg, dig_an, load_ready, seg_hi, dig_an_hi, load_ready_hi, e.seg, e.an, e.rdy);
            end
            if (i == 0)  load_valid = 1'b0;
            if (i == 80) scroll_en  = 1'b0;
        end
        cur_word = 16'h1032;
    endtask

    task automatic test_blank();
        exp_t e;
        blank_mask = 4'b0100;
        push_frame(cur_word, 4'b0100, 16'hFFFF);
        push_frame(cur_word, 4'b0000, 16'hFFFF);
        for (int i = 0; i < 2*ND*CD; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (seg !== e.seg || dig_an !== e.an || load_ready !== e.rdy ||
                seg_hi !== ~e.seg || dig_an_hi !== ~e.an || load_ready_hi !== e.rdy) begin
                errors++;
                $display("FAIL blank k=%0d: got seg=%b an=%b rdy=%b hi seg=%b an=%b rdy=%b; want seg=%b an=%b rdy=%b (hi inverted)",
                         k, seg, dig_an, load_ready, seg_hi, dig_an_hi, load_ready_hi, e.seg, e.an, e.rdy);
            end
            if (i == 15) blank_mask = 4'b0000;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        load_valid = 1'b1;
        load_data  = 16'hABCD;
        push_frame(cur_word, 4'b0000, 16'h8000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (seg !== e.seg || dig_an !== e.an || load_ready !== e.rdy ||
                seg_hi !== ~e.seg || dig_an_hi !== ~e.an || load_ready_hi !== e.rdy) begin
                errors++;
                $display("FAIL reset_mid_pre k=%0d: got seg=%b an=%b rdy=%b hi seg=%b an=%b rdy=%b; want seg=%b an=%b rdy=%b (hi inverted)",
                         k, seg, dig_an, load_ready, seg_hi, dig_an_hi, load_ready_hi, e.seg, e.an, e.rdy);
            end
            if (i == 0) load_valid = 1'b0;
            if (i == 9) rst = 1'b1;
        end
        exp_q.delete();
        repeat (2) exp_q.push_back('{7'h7F, 4'hF, 1'b1});
        push_frame(16'h0000, 4'b0000, 16'hFFFF);
        push_frame(16'h0000, 4'b0000, 16'hFFFF);
        for (int i = 0; i < 2 + 2*ND*CD; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (seg !== e.seg || dig_an !== e.an || load_ready !== e.rdy ||
                seg_hi !== ~e.seg || dig_an_hi !== ~e.an || load_ready_hi !== e.rdy) begin
                errors++;
                $display("FAIL reset_mid_post k=%0d: got seg=%b an=%b rdy=%b hi seg=%b an=%b rdy=%b; want seg=%b an=%b rdy=%b (hi inverted)",
                         k, seg, dig_an, load_ready, seg_hi, dig_an_hi, load_ready_hi, e.seg, e.an, e.rdy);
            end
            if (i == 1) rst = 1'b0;
        end
        cur_word = 16'h0000;
    endtask

    initial begin
        test_reset();
        wait_frame_start();
        test_load_decode();
        wait_frame_start();
        test_back_to_back();
        wait_frame_start();
        test_scroll();
        wait_frame_start();
        test_blank();
        wait_frame_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed multi-digit 7-segment display driver for the SPI demo board: it decodes full hexadecimal nibbles (0–F) for NUM_DIGITS common-anode digits and scans them with a programmable refresh prescaler. A new message is loaded through a valid/ready handshake and is applied only at a frame boundary, so the display never tears. An optional scroll mode rotates the message by one digit every SCROLL_FRAMES frames. The block sits after the SPI receive path and drives the board's segment and digit-enable pins directly.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits; legal range 2–8.
- CLK_DIV, 50000: clk cycles per digit slot; legal range ≥2.
- SCROLL_FRAMES, 64: full frames between scroll steps; legal range ≥1.
- ACTIVE_LOW, 1: 1 = seg/dig_an are low-true; 0 = high-true.

Ports (name, direction, width, meaning):
- clk  in  1  single clock domain for the whole block.
- rst  in  1  synchronous reset, active-high.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  block can accept a load.
- load_data  in  4*NUM_DIGITS  nibble i (bits 4i+3:4i) is digit i; digit 0 is leftmost.
- blank_mask  in  NUM_DIGITS  bit i = 1 turns all segments of digit slot i off. Sampled live.
- scroll_en  in  1  enables left rotation of the display buffer.
- seg  out  7  segment bits: seg[0]=a, seg[1]=b, …, seg[6]=g. Registered.
- dig_an  out  NUM_DIGITS  one-hot digit enable (bit i drives digit i), polarity set by ACTIVE_LOW. Registered.

## Operation
- **Prescaler:** `div_cnt` counts 0..CLK_DIV-1 and wraps. `tick` is asserted when `div_cnt == CLK_DIV-1`.
- **Digit index:** `dig_idx` advances on `tick` and wraps from NUM_DIGITS-1 to 0.
- **Frame end:** `tick` while `dig_idx == NUM_DIGITS-1`.
- **Buffers:** `disp_buf` holds the shown nibbles; `shadow_buf` plus a `pending` flag hold a new message.
- **Load handshake:**
  - A transfer occurs when `load_valid && load_ready` on a rising edge: `shadow_buf <= load_data` and `pending <= 1`.
  - `load_ready = ~pending`.
  - `load_data` is ignored while `load_ready` is 0.
- **At frame end, with priority:**
  - If `pending`: `disp_buf <= shadow_buf`, `pending <= 0`, `frame_cnt <= 0`.
  - Else if `scroll_en`: if `frame_cnt == SCROLL_FRAMES-1`, rotate `disp_buf` left by one nibble (new digit i = old digit i+1, new last digit = old digit 0) and set `frame_cnt <= 0`; otherwise increment `frame_cnt`.
  - Else `frame_cnt` holds its value.
- **Simultaneous handshake and frame end:** the pending-apply uses the old `shadow_buf`. Because `load_ready` was 0, no new transfer can happen that cycle. A transfer is only accepted when `pending` is 0, so the new data applies at the next frame end.
- **Decode:** standard hex glyph (lit segments):
  - 0: abcdef; 1: bc; 2: abdeg; 3: abcdg
  - 4: bcfg; 5: acdfg; 6: acdefg; 7: abc
  - 8: abcdefg; 9: abcdfg; A: abcefg; b: cdefg
  - C: adef; d: bcdeg; E: adefg; F: aefg
- **Outputs:**
  - Each cycle the output register loads the glyph of `disp_buf[dig_idx]`. The glyph is forced to all-off if `blank_mask[dig_idx]` is set. `dig_an` loads one-hot(`dig_idx`).
  - Both are inverted when ACTIVE_LOW=1.
- **Reset:**
  - `div_cnt`, `dig_idx`, `frame_cnt`, `disp_buf`, `shadow_buf`, `pending` = 0; `load_ready` = 1.
  - `seg` = all off (7'b1111111 when ACTIVE_LOW=1) and `dig_an` = all disabled.
  - Reset asserted mid-frame or with a load pending discards the pending data. There is no partial state.

## Timing
- seg/dig_an lag `dig_idx` by exactly 1 cycle.
- In the first cycle after reset release, outputs are still at their reset values. From the second cycle they show digit 0 (glyph "0").
- Each digit is enabled for exactly CLK_DIV consecutive cycles; one frame = NUM_DIGITS·CLK_DIV cycles.
- Load-to-display latency:
  - The load takes effect on the first frame-end tick after the transfer edge.
  - seg reflects the new data one cycle later, starting at digit 0.
  - Worst case is NUM_DIGITS·CLK_DIV+1 cycles.
- `load_ready` drops in the cycle after the transfer edge. It rises in the cycle after the applying frame-end edge.
- Scroll period = SCROLL_FRAMES frames. A load restarts the scroll phase.
- Changes on `blank_mask` are visible 1 cycle later. `scroll_en` is sampled only at frame end.

## Test plan
All scenarios use NUM_DIGITS=4, CLK_DIV=4, SCROLL_FRAMES=2, ACTIVE_LOW=1 unless noted.
1. **Reset:** hold rst 3 cycles, then release → seg=7'b1111111 and dig_an=4'b1111 on the first cycle after release; then seg=7'b1000000 with dig_an=4'b1110 for 4 cycles, then dig_an=4'b1101.
2. **Load and decode:** load_data=16'hF81A with load_valid for 1 cycle (digit0=A, digit1=1, digit2=8, digit3=F) → after the next frame end, per slot seg = 7'b0001000, 7'b1111001, 7'b0000000, 7'b0001110. load_ready is 0 from the transfer until the apply.
3. **Back-pressure:** assert load_valid continuously with 16'h1234, then 16'h5678 → the second value is not accepted until 16'h1234 is displayed. The display never shows a mix of both words.
4. **Scroll:** display 16'h3210 with scroll_en=1 → after 2 frames the slots show 1,2,3,0; after 4 frames they show 2,3,0,1. With scroll_en=0 the display is unchanged.
5. **Blanking:** blank_mask=4'b0100 → slot 2 shows seg=7'b1111111 while dig_an=4'b1011; the other slots are unaffected.
6. **Reset mid-operation:** assert rst with pending=1, mid-slot 2 → all state returns to reset values and the pending data never appears. Also repeat scenario 2 with ACTIVE_LOW=0 → the exact bitwise inverses.
